// File: rtl/or1k_branch_predictor_saturation.sv
// or1k_branch_predictor_saturation
// Table of 2-bit saturating counters predicting SR[F] for l.bf / l.bnf.
// Decode reads the table combinationally; execute trains the entry that
// was indexed when the branch left decode.
// Optional feature: define OR1K_BP_GSHARE_EN to XOR a global taken/not-taken
// history register into the table index (gshare); otherwise pure bimodal.
module or1k_branch_predictor_saturation #(
    parameter int OPTION_BP_TABLE_AW   = 6,
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            padv_decode_i,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [9:0]                      immjbr_upper_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
    output logic                            predicted_flag_o,

    input  logic                            padv_execute_i,
    input  logic                            execute_op_bf_i,
    input  logic                            execute_op_bnf_i,
    input  logic                            execute_predicted_flag_i,
    input  logic                            flag_i,
    input  logic                            pipeline_flush_i,
    output logic                            branch_mispredict_o
);

    localparam int          AW    = OPTION_BP_TABLE_AW;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    logic [1:0]    r_cnt [DEPTH];
    logic [AW-1:0] r_idx_x;
    logic          r_idx_x_valid;

    logic [AW-1:0] w_idx_d;
    logic          w_dec_branch;
    logic          w_exe_branch;
    logic          w_taken;
    logic          w_update;
    logic          w_pred_t;
    logic          w_unused;

    // Offset bits and upper PC bits are not part of the index.
    assign w_unused = ^{immjbr_upper_i, brn_pc_i};

    assign w_dec_branch = op_bf_i | op_bnf_i;
    assign w_exe_branch = execute_op_bf_i | execute_op_bnf_i;
    assign w_taken      = (execute_op_bf_i & flag_i) | (execute_op_bnf_i & ~flag_i);
    // A flush kills the resolving branch, so it must not train the table.
    assign w_update     = padv_execute_i & r_idx_x_valid & w_exe_branch & ~pipeline_flush_i;

`ifdef OR1K_BP_GSHARE_EN
    logic [AW-1:0] r_ghr;

    assign w_idx_d = brn_pc_i[AW+1:2] ^ r_ghr;

    // Global history: shift in each resolved outcome; retained across flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_update) begin
            r_ghr <= {r_ghr[AW-2:0], w_taken};
        end
    end
`else
    assign w_idx_d = brn_pc_i[AW+1:2];
`endif

    // Prediction reads the pre-update counter, so a same-cycle update is not visible yet.
    assign w_pred_t            = r_cnt[w_idx_d][1];
    assign predicted_flag_o    = (op_bf_i & w_pred_t) | (op_bnf_i & ~w_pred_t);
    assign branch_mispredict_o = w_exe_branch & (flag_i != execute_predicted_flag_i);

    // Track the index of the branch moving from decode into execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_x       <= '0;
            r_idx_x_valid <= 1'b0;
        end else if (pipeline_flush_i) begin
            r_idx_x_valid <= 1'b0;
        end else if (padv_decode_i) begin
            r_idx_x_valid <= w_dec_branch;
            if (w_dec_branch) begin
                r_idx_x <= w_idx_d;
            end
        end
    end

    // Train the counter of the resolving branch, saturating at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= CNT_WEAK_NT;
            end
        end else if (w_update) begin
            if (w_taken) begin
                if (r_cnt[r_idx_x] != CNT_STRONG_T) begin
                    r_cnt[r_idx_x] <= r_cnt[r_idx_x] + 2'd1;
                end
            end else begin
                if (r_cnt[r_idx_x] != CNT_STRONG_NT) begin
                    r_cnt[r_idx_x] <= r_cnt[r_idx_x] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_or1k_branch_predictor_saturation.sv
// Directed testbench for or1k_branch_predictor_saturation (default AW=6).
// Build with OR1K_BP_GSHARE_EN defined to exercise the gshare index path.
module tb_or1k_branch_predictor_saturation;

    logic        clk;
    logic        rst_n;
    logic        padv_decode_i;
    logic        op_bf_i;
    logic        op_bnf_i;
    logic [9:0]  immjbr_upper_i;
    logic [31:0] brn_pc_i;
    logic        predicted_flag_o;
    logic        padv_execute_i;
    logic        execute_op_bf_i;
    logic        execute_op_bnf_i;
    logic        execute_predicted_flag_i;
    logic        flag_i;
    logic        pipeline_flush_i;
    logic        branch_mispredict_o;

    int n_cmp = 0;
    int n_err = 0;

    or1k_branch_predictor_saturation #(
        .OPTION_BP_TABLE_AW  (6),
        .OPTION_OPERAND_WIDTH(32)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .padv_decode_i           (padv_decode_i),
        .op_bf_i                 (op_bf_i),
        .op_bnf_i                (op_bnf_i),
        .immjbr_upper_i          (immjbr_upper_i),
        .brn_pc_i                (brn_pc_i),
        .predicted_flag_o        (predicted_flag_o),
        .padv_execute_i          (padv_execute_i),
        .execute_op_bf_i         (execute_op_bf_i),
        .execute_op_bnf_i        (execute_op_bnf_i),
        .execute_predicted_flag_i(execute_predicted_flag_i),
        .flag_i                  (flag_i),
        .pipeline_flush_i        (pipeline_flush_i),
        .branch_mispredict_o     (branch_mispredict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // A conditional branch (l.bf) leaves decode at the given PC.
    task automatic dec(input logic [31:0] pc);
        brn_pc_i      = pc;
        op_bf_i       = 1'b1;
        padv_decode_i = 1'b1;
        cyc();
        padv_decode_i = 1'b0;
        op_bf_i       = 1'b0;
    endtask

    // The l.bf in execute resolves with the given flag.
    task automatic res(input logic fl);
        execute_op_bf_i = 1'b1;
        flag_i          = fl;
        padv_execute_i  = 1'b1;
        cyc();
        padv_execute_i  = 1'b0;
        execute_op_bf_i = 1'b0;
        flag_i          = 1'b0;
    endtask

    // Probe the prediction at a PC with l.bf (= counter bit 1) and l.bnf (= inverse).
    task automatic pchk(input string tag, input logic [31:0] pc, input logic exp_t);
        brn_pc_i = pc;
        op_bf_i  = 1'b1;
        #1 check({tag, "_bf"}, {31'd0, predicted_flag_o}, {31'd0, exp_t});
        op_bf_i  = 1'b0;
        op_bnf_i = 1'b1;
        #1 check({tag, "_bnf"}, {31'd0, predicted_flag_o}, {31'd0, ~exp_t});
        op_bnf_i = 1'b0;
    endtask

    initial begin
        rst_n                    = 1'b0;
        padv_decode_i            = 1'b0;
        op_bf_i                  = 1'b0;
        op_bnf_i                 = 1'b0;
        immjbr_upper_i           = 10'h3FF;
        brn_pc_i                 = 32'h0;
        padv_execute_i           = 1'b0;
        execute_op_bf_i          = 1'b0;
        execute_op_bnf_i         = 1'b0;
        execute_predicted_flag_i = 1'b0;
        flag_i                   = 1'b0;
        pipeline_flush_i         = 1'b0;

        // Reset: outputs idle, counters weak-NT
        #1;
        check("rst_pred_idle", {31'd0, predicted_flag_o}, 32'd0);
        check("rst_misp_idle", {31'd0, branch_mispredict_o}, 32'd0);
        pchk("rst_pc100", 32'h100, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

`ifdef OR1K_BP_GSHARE_EN
        // History T,T,NT -> ghr low bits 110; trained entry 0 went 01->10->11->10
        dec(32'h100);
        res(1'b1);
        res(1'b1);
        res(1'b0);
        check("gs_ghr", {29'd0, dut.r_ghr[2:0]}, 32'h6);
        pchk("gs_pc100_idx6", 32'h100, 1'b0);
        pchk("gs_pc118_idx0", 32'h118, 1'b1);
        // Flush with a pending branch: no training, history retained
        dec(32'h100);
        pipeline_flush_i = 1'b1;
        res(1'b1);
        pipeline_flush_i = 1'b0;
        pchk("gs_flush_pc100", 32'h100, 1'b0);
        check("gs_flush_ghr", {29'd0, dut.r_ghr[2:0]}, 32'h6);
`else
        // Training at PC 0x100 (index 0)
        dec(32'h100);
        res(1'b1);
        pchk("trn_t1", 32'h100, 1'b1);
        res(1'b1);
        pchk("trn_t2", 32'h100, 1'b1);
        res(1'b0);
        pchk("trn_nt1", 32'h100, 1'b1);
        res(1'b0);
        pchk("trn_nt2", 32'h100, 1'b0);

        // Saturation at PC 0x104 (index 1): 01 -> 11 and held
        dec(32'h104);
        for (int i = 0; i < 5; i++) begin
            res(1'b1);
            pchk($sformatf("sat_t%0d", i), 32'h104, 1'b1);
        end
        res(1'b0);
        pchk("sat_down10", 32'h104, 1'b1);
        res(1'b0);
        pchk("sat_down01", 32'h104, 1'b0);
        for (int i = 0; i < 5; i++) begin
            res(1'b0);
            pchk($sformatf("sat_nt%0d", i), 32'h104, 1'b0);
        end
        res(1'b1);
        pchk("sat_up01", 32'h104, 1'b0);
        res(1'b1);
        pchk("sat_up10", 32'h104, 1'b1);

        // Mispredict flag is combinational
        execute_op_bf_i          = 1'b1;
        execute_predicted_flag_i = 1'b0;
        flag_i                   = 1'b1;
        #1 check("misp_bf_wrong", {31'd0, branch_mispredict_o}, 32'd1);
        flag_i = 1'b0;
        #1 check("misp_bf_right", {31'd0, branch_mispredict_o}, 32'd0);
        execute_op_bf_i          = 1'b0;
        execute_op_bnf_i         = 1'b1;
        execute_predicted_flag_i = 1'b1;
        #1 check("misp_bnf_wrong", {31'd0, branch_mispredict_o}, 32'd1);
        execute_op_bnf_i = 1'b0;
        #1 check("misp_nobranch", {31'd0, branch_mispredict_o}, 32'd0);
        execute_predicted_flag_i = 1'b0;
        cyc();

        // Collision at PC 0x108 (index 2): read-before-write, then new value
        dec(32'h108);
        execute_op_bf_i = 1'b1;
        flag_i          = 1'b1;
        padv_execute_i  = 1'b1;
        brn_pc_i        = 32'h108;
        op_bf_i         = 1'b1;
        padv_decode_i   = 1'b1;
        #1 check("coll_same_cycle", {31'd0, predicted_flag_o}, 32'd0);
        cyc();
        padv_execute_i  = 1'b0;
        padv_decode_i   = 1'b0;
        execute_op_bf_i = 1'b0;
        flag_i          = 1'b0;
        #1 check("coll_next_cycle", {31'd0, predicted_flag_o}, 32'd1);
        op_bf_i = 1'b0;

        // Flush kills the pending branch at PC 0x10C (index 3)
        dec(32'h10C);
        pipeline_flush_i = 1'b1;
        res(1'b1);
        pipeline_flush_i = 1'b0;
        pchk("flush_noupd", 32'h10C, 1'b0);
        res(1'b1);
        pchk("flush_invalid", 32'h10C, 1'b0);

        // A non-branch advancing through decode invalidates the tracked entry
        dec(32'h110);
        padv_decode_i = 1'b1;
        cyc();
        padv_decode_i = 1'b0;
        res(1'b1);
        pchk("nonbr_invalid", 32'h110, 1'b0);

        // Reset mid-operation: entry 0 trained to 11, then reset
        dec(32'h100);
        res(1'b1);
        res(1'b1);
        pchk("mid_trained", 32'h100, 1'b1);
        rst_n = 1'b0;
        pchk("mid_in_reset", 32'h100, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        res(1'b1);
        pchk("mid_pending_dropped", 32'h100, 1'b0);
        dec(32'h100);
        res(1'b0);
        pchk("mid_first_nt", 32'h100, 1'b0);
        res(1'b1);
        pchk("mid_back01", 32'h100, 1'b0);
        res(1'b1);
        pchk("mid_up10", 32'h100, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
